proj_fm_ctrl: RTL

Ping-pong scheduler for the projection feature-map buffer bank set. It owns the write and read pointers and the per-bank full flags, and applies valid/ready handshakes on both sides: a byte-stream producer on the write side and a windowed consumer on the read side. It sits between the hash front-end and the FM RAM and drives the RAM's write/read address and bank-select inputs.

---
 rtl/proj_fm_pkg.sv | 24 ++
 rtl/proj_fm_bank_flags.sv | 50 +++++
 rtl/proj_fm_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/proj_fm_pkg.sv
// proj_fm_pkg: shared types and constants for the projection feature-map
// buffer controller.
//   rd_state_e         : read-side FSM states
//   DEF_*              : default bank geometry
//   STATS_W            : width of the optional statistics counters
//   sat_inc()          : saturating increment used by the statistics counters
package proj_fm_pkg;

    typedef enum logic [0:0] {
        RD_IDLE   = 1'b0,
        RD_ACTIVE = 1'b1
    } rd_state_e;

    localparam int unsigned DEF_BUFFER_COUNT         = 2;
    localparam int unsigned DEF_BUFFER_SIZE          = 64;
    localparam int unsigned DEF_READ_ADDRESSES_COUNT = 2;

    localparam int unsigned STATS_W = 16;

    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/proj_fm_bank_flags.sv
// proj_fm_bank_flags: per-bank full-flag vector.
// Ports:
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   clr_all_i          : synchronous clear of every flag (highest priority)
//   set_i, set_idx_i   : set the flag of bank set_idx_i
//   clr_i, clr_idx_i   : clear the flag of bank clr_idx_i
//   full_o             : current flags
// A set and a clear on the same edge always target different banks, so both
// are applied independently.
module proj_fm_bank_flags
    import proj_fm_pkg::*;
#(
    parameter int unsigned BUFFER_COUNT = DEF_BUFFER_COUNT
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            clr_all_i,
    input  logic                            set_i,
    input  logic [$clog2(BUFFER_COUNT)-1:0] set_idx_i,
    input  logic                            clr_i,
    input  logic [$clog2(BUFFER_COUNT)-1:0] clr_idx_i,
    output logic [BUFFER_COUNT-1:0]         full_o
);

    logic [BUFFER_COUNT-1:0] full_q, full_d;

    always_comb begin
        full_d = full_q;
        if (clr_i) begin
            full_d[clr_idx_i] = 1'b0;
        end
        if (set_i) begin
            full_d[set_idx_i] = 1'b1;
        end
        if (clr_all_i) begin
            full_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= '0;
        end else begin
            full_q <= full_d;
        end
    end

    assign full_o = full_q;

endmodule

// File: rtl/proj_fm_ctrl.sv
// proj_fm_ctrl: ping-pong scheduler for the projection feature-map buffer banks.
// Owns write/read pointers and per-bank full flags; drives FM RAM addressing.
// Ports:
//   in_clk, in_rst_n    : clock, asynchronous active-low reset
//   in_soft_clr         : synchronous clear of pointers, flags and counters
//   in_wr_valid         : producer byte valid
//   out_wr_ready        : byte accepted when high together with in_wr_valid
//   out_we              : RAM write strobe
//   out_wr_idx/waddr    : RAM write bank / byte address
//   out_rd_valid        : read window available
//   in_rd_ready         : consumer takes the window
//   out_rd_idx/raddr    : RAM read bank / window base address
//   out_rdata_valid     : RAM read data valid, one cycle after a window accept
//   out_bank_full       : per-bank full flags
// Optional (macro PROJ_FM_CTRL_STATS_EN): out_wr_stall_cnt, out_rd_stall_cnt,
// out_bank_done_cnt, 16-bit saturating counters.
module proj_fm_ctrl
    import proj_fm_pkg::*;
#(
    parameter int unsigned BUFFER_COUNT         = DEF_BUFFER_COUNT,
    parameter int unsigned BUFFER_SIZE          = DEF_BUFFER_SIZE,
    parameter int unsigned READ_ADDRESSES_COUNT = DEF_READ_ADDRESSES_COUNT
) (
    input  logic                            in_clk,
    input  logic                            in_rst_n,
    input  logic                            in_soft_clr,
    input  logic                            in_wr_valid,
    output logic                            out_wr_ready,
    output logic                            out_we,
    output logic [$clog2(BUFFER_COUNT)-1:0] out_wr_idx,
    output logic [$clog2(BUFFER_SIZE)-1:0]  out_waddr,
    output logic                            out_rd_valid,
    input  logic                            in_rd_ready,
    output logic [$clog2(BUFFER_COUNT)-1:0] out_rd_idx,
    output logic [$clog2(BUFFER_SIZE)-1:0]  out_raddr,
    output logic                            out_rdata_valid,
    output logic [BUFFER_COUNT-1:0]         out_bank_full
`ifdef PROJ_FM_CTRL_STATS_EN
    ,
    output logic [STATS_W-1:0]              out_wr_stall_cnt,
    output logic [STATS_W-1:0]              out_rd_stall_cnt,
    output logic [STATS_W-1:0]              out_bank_done_cnt
`endif
);

    localparam int unsigned IdxW  = $clog2(BUFFER_COUNT);
    localparam int unsigned AddrW = $clog2(BUFFER_SIZE);
    localparam logic [AddrW-1:0] WLast = AddrW'(BUFFER_SIZE - 1);
    localparam logic [AddrW-1:0] RLast = AddrW'(BUFFER_SIZE - READ_ADDRESSES_COUNT);
    localparam logic [AddrW-1:0] RStep = AddrW'(READ_ADDRESSES_COUNT);

    // run_q holds wr_ready low during reset and for the first edge after it.
    logic             run_q;
    logic [IdxW-1:0]  wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [AddrW-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
    rd_state_e        rd_state_q, rd_state_d;
    logic             rdata_valid_q;

    logic [BUFFER_COUNT-1:0] full;
    logic wr_ready, wr_acc, wr_last;
    logic rd_valid, rd_acc, rd_last;

    assign wr_ready = run_q & ~full[wr_idx_q] & ~in_soft_clr;
    assign wr_acc   = in_wr_valid & wr_ready;
    assign wr_last  = wr_acc & (waddr_q == WLast);

    assign rd_valid = (rd_state_q == RD_ACTIVE);
    // A soft clear overrides the read handshake too.
    assign rd_acc   = rd_valid & in_rd_ready & ~in_soft_clr;
    assign rd_last  = rd_acc & (raddr_q == RLast);

    // Write pointer: waddr wraps naturally at the bank boundary.
    always_comb begin
        waddr_d  = waddr_q;
        wr_idx_d = wr_idx_q;
        if (in_soft_clr) begin
            waddr_d  = '0;
            wr_idx_d = '0;
        end else if (wr_acc) begin
            waddr_d = waddr_q + 1'b1;
            if (wr_last) begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end
    end

    // Read FSM: the idle state spends one cycle sampling the bank flag.
    always_comb begin
        rd_state_d = rd_state_q;
        raddr_d    = raddr_q;
        rd_idx_d   = rd_idx_q;
        if (in_soft_clr) begin
            rd_state_d = RD_IDLE;
            raddr_d    = '0;
            rd_idx_d   = '0;
        end else begin
            unique case (rd_state_q)
                RD_IDLE: begin
                    if (full[rd_idx_q]) begin
                        rd_state_d = RD_ACTIVE;
                        raddr_d    = '0;
                    end
                end
                RD_ACTIVE: begin
                    if (rd_acc) begin
                        raddr_d = raddr_q + RStep;
                        if (rd_last) begin
                            raddr_d    = '0;
                            rd_idx_d   = rd_idx_q + 1'b1;
                            rd_state_d = RD_IDLE;
                        end
                    end
                end
                default: rd_state_d = RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            run_q         <= 1'b0;
            wr_idx_q      <= '0;
            waddr_q       <= '0;
            rd_idx_q      <= '0;
            raddr_q       <= '0;
            rd_state_q    <= RD_IDLE;
            rdata_valid_q <= 1'b0;
        end else begin
            run_q         <= 1'b1;
            wr_idx_q      <= wr_idx_d;
            waddr_q       <= waddr_d;
            rd_idx_q      <= rd_idx_d;
            raddr_q       <= raddr_d;
            rd_state_q    <= rd_state_d;
            rdata_valid_q <= rd_acc;
        end
    end

    proj_fm_bank_flags #(
        .BUFFER_COUNT(BUFFER_COUNT)
    ) u_flags (
        .clk_i     (in_clk),
        .rst_ni    (in_rst_n),
        .clr_all_i (in_soft_clr),
        .set_i     (wr_last),
        .set_idx_i (wr_idx_q),
        .clr_i     (rd_last),
        .clr_idx_i (rd_idx_q),
        .full_o    (full)
    );

    assign out_wr_ready    = wr_ready;
    assign out_we          = wr_acc;
    assign out_wr_idx      = wr_idx_q;
    assign out_waddr       = waddr_q;
    assign out_rd_valid    = rd_valid;
    assign out_rd_idx      = rd_idx_q;
    assign out_raddr       = raddr_q;
    assign out_rdata_valid = rdata_valid_q;
    assign out_bank_full   = full;

`ifdef PROJ_FM_CTRL_STATS_EN
    logic [STATS_W-1:0] wr_stall_q, rd_stall_q, done_q;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            wr_stall_q <= '0;
            rd_stall_q <= '0;
            done_q     <= '0;
        end else if (in_soft_clr) begin
            wr_stall_q <= '0;
            rd_stall_q <= '0;
            done_q     <= '0;
        end else begin
            if (in_wr_valid && !wr_ready) begin
                wr_stall_q <= sat_inc(wr_stall_q);
            end
            if (rd_valid && !in_rd_ready) begin
                rd_stall_q <= sat_inc(rd_stall_q);
            end
            if (rd_last) begin
                done_q <= sat_inc(done_q);
            end
        end
    end

    assign out_wr_stall_cnt  = wr_stall_q;
    assign out_rd_stall_cnt  = rd_stall_q;
    assign out_bank_done_cnt = done_q;
`endif

endmodule
